// File: rtl/rm_pkg.sv
// rtl/rm_pkg.sv - shared defaults, accumulator width function and sample type for the running-mean path
package rm_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int WIN_LOG2_DEF = 4;

    // Summing 2^win_log2 samples grows the magnitude by at most win_log2 bits.
    function automatic int acc_w(input int data_w, input int win_log2);
        return data_w + win_log2;
    endfunction

    typedef logic signed [DATA_W_DEF-1:0] sample_t;

endpackage

// File: rtl/rm_window_buf.sv
// rtl/rm_window_buf.sv - N x DATA_W circular sample buffer, combinational read of the oldest entry
module rm_window_buf
    import rm_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int WIN_LOG2 = WIN_LOG2_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);

    localparam int N = 1 << WIN_LOG2;

    logic [DATA_W-1:0]   mem [N];
    logic [WIN_LOG2-1:0] wptr;

    // The slot about to be overwritten holds the oldest sample in the window.
    assign rd_data = mem[wptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                mem[i] <= '0;
            end
            wptr <= '0;
        end else if (wr_en) begin
            mem[wptr] <= wr_data;
            wptr      <= wptr + WIN_LOG2'(1);
        end
    end

endmodule

// File: rtl/running_mean_gen.sv
// rtl/running_mean_gen.sv - sliding-window mean of the samples preceding each input; option RUNNING_MEAN_PRIMED_GATE_EN
module running_mean_gen
    import rm_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int WIN_LOG2 = WIN_LOG2_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] out_sample,
    output logic signed [DATA_W-1:0] out_mean,
    output logic                     primed
);

    localparam int ACC_W = acc_w(DATA_W, WIN_LOG2);
    localparam logic [WIN_LOG2:0] FULL = {1'b1, {WIN_LOG2{1'b0}}};

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_next;
    logic signed [ACC_W-1:0] in_ext;
    logic signed [ACC_W-1:0] old_ext;
    logic [DATA_W-1:0]       old_data;
    logic [WIN_LOG2:0]       fill;
    logic [WIN_LOG2:0]       fill_inc;
    logic                    primed_next;

    rm_window_buf #(
        .DATA_W   (DATA_W),
        .WIN_LOG2 (WIN_LOG2)
    ) u_window_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (in_valid),
        .wr_data (in_data),
        .rd_data (old_data)
    );

    always_comb begin
        in_ext      = ACC_W'(in_data);
        old_ext     = ACC_W'($signed(old_data));
        acc_next    = acc + in_ext - old_ext;
        fill_inc    = fill + (WIN_LOG2 + 1)'(1);
        primed_next = primed | (fill_inc >= FULL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc        <= '0;
            fill       <= '0;
            out_valid  <= 1'b0;
            out_sample <= '0;
            out_mean   <= '0;
            primed     <= 1'b0;
        end else if (in_valid) begin
            out_sample <= in_data;
            // Mean uses the pre-update sum so the new sample never biases its own reference.
            out_mean   <= DATA_W'(acc >>> WIN_LOG2);
            acc        <= acc_next;
            fill       <= (fill == FULL) ? fill : fill_inc;
            primed     <= primed_next;
`ifdef RUNNING_MEAN_PRIMED_GATE_EN
            out_valid  <= primed_next;
`else
            out_valid  <= 1'b1;
`endif
        end else begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_running_mean_gen.sv
// tb/tb_running_mean_gen.sv - scoreboard bench for running_mean_gen
module tb_running_mean_gen;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic signed [31:0] in_data = '0;
    logic               out_valid;
    logic signed [31:0] out_sample;
    logic signed [31:0] out_mean;
    logic               primed;

    running_mean_gen dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_sample (out_sample),
        .out_mean   (out_mean),
        .primed     (primed)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint sample;
        longint mean;
    } exp_t;

    exp_t   sb_q[$];
    int     checks   = 0;
    int     failures = 0;

    longint m_buf[16];
    int     m_ptr;
    int     m_fill;
    longint m_sum;
    logic   exp_valid;
    logic   exp_primed;
    longint exp_sample;
    longint exp_mean;

    task automatic check(input string tag, input longint got, input longint want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, want);
        end
    endtask

    function automatic longint floor_div16(input longint s);
        if (s >= 0) return s / 16;
        return -((-s + 15) / 16);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_buf[i] = 0;
        m_ptr = 0; m_fill = 0; m_sum = 0;
        exp_valid = 1'b0; exp_primed = 1'b0; exp_sample = 0; exp_mean = 0;
        sb_q.delete();
    endtask

    task automatic step(input logic v, input logic r, input longint d);
        exp_t e;
        @(negedge clk);
        in_valid = v;
        rst      = r;
        in_data  = 32'(d);
        if (r) begin
            model_reset();
        end else if (v) begin
            exp_mean   = floor_div16(m_sum);
            exp_sample = d;
            m_sum      = m_sum + d - m_buf[m_ptr];
            m_buf[m_ptr] = d;
            m_ptr      = (m_ptr + 1) % 16;
            if (m_fill < 16) m_fill++;
            exp_primed = (m_fill >= 16);
`ifdef RUNNING_MEAN_PRIMED_GATE_EN
            exp_valid  = exp_primed;
`else
            exp_valid  = 1'b1;
`endif
            if (exp_valid) begin
                e.sample = exp_sample;
                e.mean   = exp_mean;
                sb_q.push_back(e);
            end
        end else begin
            exp_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        check("out_valid", out_valid, exp_valid);
        check("primed", primed, exp_primed);
        check("hold_sample", out_sample, exp_sample);
        check("hold_mean", out_mean, exp_mean);
        if (out_valid) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_output", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check("sb_sample", out_sample, e.sample);
                check("sb_mean", out_mean, e.mean);
            end
        end
    endtask

    initial begin
        model_reset();
        step(1'b0, 1'b1, 0);
        step(1'b0, 1'b1, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_primed", primed, 0);
        check("rst_out_mean", out_mean, 0);
        check("rst_out_sample", out_sample, 0);

        // Ramp-up with a constant 100: means 0, 6, 12, 18, ...
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 100);
            if (i == 1) check("ramp_mean_2", out_mean, 6);
            if (i == 3) check("ramp_mean_4", out_mean, 18);
            if (i == 14) check("primed_before_16", primed, 0);
        end
        check("primed_at_16", primed, 1);
        step(1'b1, 1'b0, 100);
        check("mean_17", out_mean, 100);

        // Spike never contaminates its own reference.
        step(1'b1, 1'b0, 1000);
        check("spike_sample", out_sample, 1000);
        check("spike_mean", out_mean, 100);
        step(1'b1, 1'b0, 100);
        check("post_spike_mean", out_mean, 156);

        // Alternating -3/-4 window: floor(-3.5) = -4.
        step(1'b0, 1'b1, 0);
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, (i % 2) ? -4 : -3);
        step(1'b1, 1'b0, 0);
        check("neg_floor_mean", out_mean, -4);

        // Full-scale extremes.
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 64'sd2147483647);
        step(1'b1, 1'b0, -64'sd2147483648);
        check("max_mean", out_mean, 64'sd2147483647);
        for (int i = 0; i < 15; i++) step(1'b1, 1'b0, -64'sd2147483648);
        step(1'b1, 1'b0, 0);
        check("min_mean", out_mean, -64'sd2147483648);

        // Sparse input: one on, three off.
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 1'b0, longint'($urandom_range(2000)) - 1000);
            for (int g = 0; g < 3; g++) step(1'b0, 1'b0, 0);
        end

        // Reset collides with a valid sample, which must be dropped.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 500 + i);
        step(1'b1, 1'b1, 777);
        check("midrst_primed", primed, 0);
        check("midrst_valid", out_valid, 0);
        step(1'b1, 1'b0, 321);
        check("post_rst_mean", out_mean, 0);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, longint'($urandom_range(400)) - 200);
        step(1'b0, 1'b0, 0);

        check("sb_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/running_mean_gen.md
Name: running_mean_gen

Overview:
- Produces the running-mean operand consumed by the spike threshold comparator.
- Keeps a sliding window of the last 2^WIN_LOG2 input samples.
- Each output pairs the incoming sample with the mean of the N samples that precede it, so a spike never contaminates its own reference.
- Sits between the sample source and the threshold compare stage.

Parameters:
- DATA_W, 32: sample width, signed two's complement.
- WIN_LOG2, 4: log2 of window length; N = 2^WIN_LOG2 (16); legal range 1..10.

Ports:
- clk  in  1  single clock, all logic rising-edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  one new sample this cycle; may be high on consecutive cycles; no backpressure.
- in_data  in  DATA_W  signed input sample.
- out_valid  out  1  out_sample/out_mean valid this cycle.
- out_sample  out  DATA_W  signed sample aligned with out_mean (feeds comparator X).
- out_mean  out  DATA_W  signed mean of the N samples before out_sample (feeds comparator M).
- primed  out  1  high once N samples have entered the window since reset.

Behaviour:
- Reset (rst high at a clk edge) forces the following on the next edge:
  - window buffer entries to 0 and write pointer to 0;
  - accumulator and fill count to 0;
  - out_valid, out_sample, out_mean and primed to 0.
- rst takes priority over in_valid in the same cycle; that sample is discarded.
- Accumulator width ACC_W = DATA_W + WIN_LOG2, signed. It never overflows.
- On a clk edge with in_valid=1 (and rst=0):
  - out_sample <= in_data.
  - out_mean <= acc >>> WIN_LOG2, using the accumulator value before this sample. The shift is arithmetic (floor toward -inf), then truncated to DATA_W; the truncation is lossless.
  - acc <= acc + in_data - buf[wptr], with both operands sign-extended to ACC_W.
  - buf[wptr] <= in_data.
  - wptr <= wptr + 1, wrapping modulo N.
  - fill <= min(fill + 1, N); primed <= (fill + 1 >= N).
  - out_valid <= 1.
- On a clk edge with in_valid=0: out_valid <= 0. out_sample and out_mean hold their last values. acc, buf, wptr and fill are unchanged.
- Latency: exactly 1 cycle from in_valid to out_valid. Throughput is 1 sample per cycle.
- Before primed, empty window slots count as 0; out_mean is still acc/N and out_valid still asserts.
- Once primed, it stays high until reset.
- Window buffer read is combinational (or same-edge read-before-write) so buf[wptr] returns the oldest sample even on back-to-back inputs.
- Reset mid-stream clears all history; the first output after reset has out_mean = 0.

Optional Feature:
- Macro RUNNING_MEAN_PRIMED_GATE_EN.
- Defined: out_valid is asserted only when primed is also true after the update. The first N-1 samples after reset produce no out_valid; the window still updates.
- Undefined: behaviour exactly as above; out_valid follows in_valid with 1-cycle latency regardless of primed.

Decomposition:
- Shared package rm_pkg holds:
  - DATA_W default;
  - WIN_LOG2 default;
  - a constant function acc_w(DATA_W, WIN_LOG2);
  - the signed sample typedef, reused by the comparator.
- One sub-module: rm_window_buf. It is an N x DATA_W circular buffer with synchronous write, combinational read at the write pointer, synchronous clear on rst, and owns wptr.
- Accumulator, fill counter and output registers stay in the top.

Test Plan:
- Reset then 16 samples of 100 on consecutive cycles:
  - out_mean = 0, 6, 12, 18, … (acc/16 floored);
  - primed rises with the 16th output;
  - a 17th sample of 100 yields out_mean = 100.
- Window full of 100, then in_data = 1000 (spike): out_sample = 1000 and out_mean = 100. The next sample of 100 gives out_mean = (15*100 + 1000)/16 = 156.
- Window of -3 and -4 values alternating (sum -56): out_mean = -4 (floor of -3.5), confirming the arithmetic shift.
- Extreme values, 16 x 0x7FFFFFFF then 16 x 0x80000000: no accumulator overflow; means are 0x7FFFFFFF then 0x80000000 once each window is fully replaced.
- in_valid gaps (1 on, 3 off, repeating) and rst asserted mid-window together with in_valid:
  - out_valid is exactly 1 cycle after each accepted sample and holds values during gaps;
  - after reset, primed = 0 and the next out_mean = 0.
- Build with RUNNING_MEAN_PRIMED_GATE_EN: no out_valid for samples 1-15; out_valid first asserts with sample 16, mean of 15 real samples plus one zero slot.
